// File: rtl/async_transmitter_scard_pkg.sv
// async_transmitter_scard_pkg: shared clock/frame constants and FSM state type
`ifndef UART_CLK
`define UART_CLK 25000000
`endif
`ifndef SCARD_DATA_BITS
`define SCARD_DATA_BITS 8
`endif
`ifndef SCARD_STOP_BITS
`define SCARD_STOP_BITS 2
`endif

package async_transmitter_scard_pkg;
  localparam int UartClk = `UART_CLK;
  localparam int ScardDataBits = `SCARD_DATA_BITS;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, GAP} state_t;
endpackage

// File: rtl/async_transmitter_scard_baud8_gen.sv
// scard_baud8_gen: fractional accumulator producing a tick at 8x the bit rate
module scard_baud8_gen
  import async_transmitter_scard_pkg::*;
#(
  parameter int ClkFrequency = UartClk,
  parameter int Baud = 9600
) (
  input  logic clk,
  input  logic rst,
  output logic Baud8Tick
);
  localparam longint Inc = ((longint'(Baud) * 8 << 9) + (ClkFrequency >> 8)) / (ClkFrequency >> 7);
  logic [16:0] acc;
  // free-running accumulator; carry out of bit 15 is the tick
  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else acc <= {1'b0, acc[15:0]} + 17'(Inc);
  end
  assign Baud8Tick = acc[16];
endmodule

// File: rtl/async_transmitter_scard.sv
// async_transmitter_scard: smartcard serial transmitter with error-signal retry
module async_transmitter_scard
  import async_transmitter_scard_pkg::*;
#(
  parameter int ClkFrequency = UartClk,
  parameter int Baud = 9600,
  parameter int MaxRetries = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  input  logic       TxD_sense,
  output logic       TxD,
  output logic       TxD_busy,
  output logic       TxD_done,
  output logic       TxD_error
);
  state_t state;
  logic baud8Tick, bitEnd, parity, errFlag;
  logic [2:0] sub, idx;
  logic [1:0] senseSync;
  logic [7:0] retries;
  logic [ScardDataBits-1:0] data;
  scard_baud8_gen #(.ClkFrequency(ClkFrequency), .Baud(Baud)) baudGen (
    .clk(clk),
    .rst(rst),
    .Baud8Tick(baud8Tick)
  );
  assign bitEnd = baud8Tick && sub == 3'd7;
  // frame sequencer; an accepted byte waits in IDLE with busy set until the next tick drops the line
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sub <= '0;
      idx <= '0;
      data <= '0;
      parity <= 1'b0;
      retries <= '0;
      errFlag <= 1'b0;
      senseSync <= '0;
      TxD <= 1'b1;
      TxD_busy <= 1'b0;
      TxD_done <= 1'b0;
      TxD_error <= 1'b0;
    end else begin
      senseSync <= {senseSync[0], TxD_sense};
      TxD_done <= 1'b0;
      TxD_error <= 1'b0;
      if (state != IDLE && baud8Tick) sub <= sub + 3'd1;
      if (state == STOP1 && baud8Tick && sub == 3'd3 && !senseSync[1]) errFlag <= 1'b1;
      case (state)
        IDLE: begin
          if (!TxD_busy && TxD_start) begin
            data <= TxD_data;
            parity <= ^TxD_data;
            retries <= '0;
            errFlag <= 1'b0;
            sub <= '0;
            TxD_busy <= 1'b1;
          end else if (TxD_busy && baud8Tick) begin
            state <= START;
            TxD <= 1'b0;
          end
        end
        START: if (bitEnd) begin
          state <= DATA;
          idx <= '0;
          TxD <= data[0];
        end
        DATA: if (bitEnd) begin
          if (idx == 3'd7) begin
            state <= PARITY;
            TxD <= parity;
          end else begin
            idx <= idx + 3'd1;
            TxD <= data[idx + 3'd1];
          end
        end
        PARITY: if (bitEnd) begin
          state <= STOP1;
          TxD <= 1'b1;
        end
        STOP1: if (bitEnd) state <= STOP2;
        STOP2: if (bitEnd) begin
          if (errFlag && retries < 8'(MaxRetries)) begin
            retries <= retries + 8'd1;
            errFlag <= 1'b0;
            state <= GAP;
          end else begin
            TxD_done <= !errFlag;
            TxD_error <= errFlag;
            TxD_busy <= 1'b0;
            state <= IDLE;
          end
        end
        GAP: if (bitEnd) begin
          state <= START;
          TxD <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_async_transmitter_scard.sv
// tb_async_transmitter_scard: directed frame, retry, reset and busy-poke checks
module tb_async_transmitter_scard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic TxD_start = 1'b0;
  logic forceLow = 1'b0;
  logic [7:0] TxD_data = 8'h00;
  logic TxD_sense, TxD, TxD_busy, TxD_done, TxD_error;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int doneCnt = 0;
  int errCnt = 0;

  typedef struct {
    logic [7:0] d;
    logic par;
    logic [3:0] mask;
    int attempts;
    bit ok;
    bit poke;
  } vec_t;
  vec_t vecs[7];

  assign TxD_sense = TxD & ~forceLow;

  async_transmitter_scard #(.ClkFrequency(3200000), .Baud(100000), .MaxRetries(3)) dut (
    .clk(clk),
    .rst(rst),
    .TxD_start(TxD_start),
    .TxD_data(TxD_data),
    .TxD_sense(TxD_sense),
    .TxD(TxD),
    .TxD_busy(TxD_busy),
    .TxD_done(TxD_done),
    .TxD_error(TxD_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (TxD_done) doneCnt <= doneCnt + 1;
    if (TxD_error) errCnt <= errCnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic sendByte(input vec_t v);
    int d0, e0, w, first, fall;
    logic [11:0] frame;
    frame = {2'b11, v.par, v.d, 1'b0};
    d0 = doneCnt;
    e0 = errCnt;
    first = 0;
    fall = 0;
    @(negedge clk);
    TxD_data = v.d;
    TxD_start = 1'b1;
    @(negedge clk);
    TxD_start = 1'b0;
    TxD_data = 8'h00;
    chk("busy_after_accept", TxD_busy, 1);
    for (int a = 0; a < v.attempts; a++) begin
      w = 0;
      while (TxD === 1'b1 && w < 100) begin
        @(negedge clk);
        w++;
      end
      chk("fall_found", w < 100, 1);
      if (a == 0) begin
        chk("fall_latency", w <= 4, 1);
        first = cyc;
      end else chk("retry_spacing", cyc - fall, 416);
      fall = cyc;
      for (int k = 0; k < 12; k++) begin
        repeat (k == 0 ? 16 : 32) @(negedge clk);
        chk($sformatf("d%02h_try%0d_bit%0d", v.d, a, k), TxD, frame[k]);
        if (k == 9) forceLow = v.mask[a];
        if (k == 11) forceLow = 1'b0;
        if (k == 3 && v.poke) begin
          TxD_data = 8'hFF;
          TxD_start = 1'b1;
          @(negedge clk);
          TxD_start = 1'b0;
          TxD_data = 8'h00;
        end
      end
    end
    w = 0;
    while (!TxD_done && !TxD_error && w < 64) begin
      @(negedge clk);
      w++;
    end
    chk("pulse_seen", w < 64, 1);
    chk("pulse_time", cyc - first, 384 + 416 * (v.attempts - 1));
    chk("done_pulse", TxD_done, v.ok);
    chk("error_pulse", TxD_error, !v.ok);
    chk("busy_drop", TxD_busy, 0);
    @(negedge clk);
    chk("pulse_width", TxD_done | TxD_error, 0);
    chk("done_count", doneCnt - d0, v.ok);
    chk("err_count", errCnt - e0, !v.ok);
    if (v.poke) begin
      w = 0;
      repeat (300) begin
        @(negedge clk);
        if (TxD !== 1'b1 || TxD_busy !== 1'b0) w++;
      end
      chk("poke_no_extra_frame", w, 0);
      chk("poke_done_count", doneCnt - d0, 1);
    end
  endtask

  initial begin
    int w, d0, e0;
    vecs[0] = '{8'h3B, 1'b1, 4'b0000, 1, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 4'b0000, 1, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 4'b0000, 1, 1'b1, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 4'b0000, 1, 1'b1, 1'b1};
    vecs[4] = '{8'h5A, 1'b0, 4'b0001, 2, 1'b1, 1'b0};
    vecs[5] = '{8'hC3, 1'b0, 4'b1111, 4, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 1'b1, 4'b0111, 4, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_txd", TxD, 1);
    chk("rst_busy", TxD_busy, 0);
    chk("rst_done", TxD_done, 0);
    chk("rst_error", TxD_error, 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    TxD_start = 1'b1;
    TxD_data = 8'h3B;
    @(negedge clk);
    rst = 1'b0;
    TxD_start = 1'b0;
    chk("rst_start_busy", TxD_busy, 0);
    w = 0;
    repeat (40) begin
      @(negedge clk);
      if (TxD !== 1'b1) w++;
    end
    chk("rst_start_line_idle", w, 0);
    TxD_data = 8'h00;
    TxD_start = 1'b1;
    @(negedge clk);
    TxD_start = 1'b0;
    w = 0;
    while (TxD === 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("midrst_fall_found", w < 100, 1);
    repeat (4 * 32 + 16) @(negedge clk);
    chk("midrst_bit3_low", TxD, 0);
    d0 = doneCnt;
    e0 = errCnt;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_txd", TxD, 1);
    chk("midrst_busy", TxD_busy, 0);
    rst = 1'b0;
    w = 0;
    repeat (500) begin
      @(negedge clk);
      if (TxD !== 1'b1 || TxD_busy !== 1'b0) w++;
    end
    chk("midrst_stays_idle", w, 0);
    chk("midrst_no_done", doneCnt - d0, 0);
    chk("midrst_no_error", errCnt - e0, 0);
    for (int i = 0; i < 7; i++) sendByte(vecs[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
